// File: rtl/bsg_chip_mem_responder_if.sv
// rtl/bsg_chip_mem_responder_if.sv - memory command/response channel between the chip and the responder
// The responder takes the slave modport; the chip side (or a bench) takes master.
interface bsg_chip_mem_responder_if #(
  parameter int msg_width_p = 559
);
  logic [msg_width_p-1:0] mem_cmd_i;
  logic                   mem_cmd_v_i;
  logic                   mem_cmd_ready_o;
  logic [msg_width_p-1:0] mem_resp_o;
  logic                   mem_resp_v_o;
  logic                   mem_resp_yumi_i;

  modport slave (
    input  mem_cmd_i,
    input  mem_cmd_v_i,
    output mem_cmd_ready_o,
    output mem_resp_o,
    output mem_resp_v_o,
    input  mem_resp_yumi_i
  );

  modport master (
    output mem_cmd_i,
    output mem_cmd_v_i,
    input  mem_cmd_ready_o,
    input  mem_resp_o,
    input  mem_resp_v_o,
    output mem_resp_yumi_i
  );
endinterface

// File: rtl/bsg_chip_mem_responder.sv
// rtl/bsg_chip_mem_responder.sv - single-outstanding memory endpoint backed by a flop array
// Accepts one command, touches the array on the accept edge, answers after latency_p wait cycles.
module bsg_chip_mem_responder #(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  parameter int els_p         = 1024,
  parameter int latency_p     = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_chip_mem_responder_if.slave mem
);
  localparam int msg_width_lp   = 4 + paddr_width_p + 3 + block_width_p;
  localparam int block_bytes_lp = block_width_p / 8;
  localparam int offset_lp      = $clog2(block_bytes_lp);
  localparam int lg_els_lp      = $clog2(els_p);
  localparam int cnt_width_lp   = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                   state_q, state_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [msg_width_lp-1:0]  resp_q, resp_d;
  logic                     accept;

  logic [3:0]               cmd_type;
  logic [paddr_width_p-1:0] cmd_addr;
  logic [2:0]               cmd_size;
  logic [block_width_p-1:0] cmd_data;
  logic [lg_els_lp-1:0]     idx;
  logic                     is_write;

  logic [block_width_p-1:0] mem_q [els_p];
  logic [block_width_p-1:0] cur_block, uc_wr_block, uc_rd_block, wr_block, resp_data;

  assign cmd_type = mem.mem_cmd_i[3:0];
  assign cmd_addr = mem.mem_cmd_i[4 +: paddr_width_p];
  assign cmd_size = mem.mem_cmd_i[4 + paddr_width_p +: 3];
  assign cmd_data = mem.mem_cmd_i[7 + paddr_width_p +: block_width_p];

  // Upper address bits beyond the index are dropped, so addresses alias modulo els_p blocks.
  assign idx       = cmd_addr[offset_lp +: lg_els_lp];
  assign cur_block = mem_q[idx];
  assign is_write  = (cmd_type == 4'd1) || (cmd_type == 4'd3);

  always_comb begin
    int lg_size;
    int nbytes;
    int base;
    lg_size     = (int'(cmd_size) > offset_lp) ? offset_lp : int'(cmd_size);
    nbytes      = 1 << lg_size;
    base        = int'(cmd_addr[offset_lp-1:0]) & ~(nbytes - 1);
    uc_wr_block = cur_block;
    uc_rd_block = '0;
    for (int i = 0; i < block_bytes_lp; i++) begin
      if (i >= base && i < base + nbytes) begin
        uc_wr_block[8*i +: 8] = cmd_data[8*(i - base) +: 8];
      end
      uc_rd_block[8*i +: 8] = cur_block[8*(base + (i & (nbytes - 1))) +: 8];
    end
  end

  assign wr_block = (cmd_type == 4'd1) ? cmd_data : uc_wr_block;

  always_comb begin
    case (cmd_type)
      4'd1, 4'd3: resp_data = '0;
      4'd2:       resp_data = uc_rd_block;
      default:    resp_data = cur_block;
    endcase
  end

  assign resp_d = {resp_data, cmd_size, cmd_addr, cmd_type};

  // Array contents are deliberately not reset; they survive a mid-transaction reset.
  always_ff @(posedge clk_i) begin
    if (accept && is_write) begin
      mem_q[idx] <= wr_block;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem.mem_cmd_v_i && reset_n_i) begin
          accept  = 1'b1;
          cnt_d   = cnt_width_lp'(latency_p);
          state_d = (latency_p > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - cnt_width_lp'(1);
        if (cnt_q == cnt_width_lp'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem.mem_resp_yumi_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        resp_q <= resp_d;
      end
    end
  end

  assign mem.mem_cmd_ready_o = (state_q == S_IDLE) && reset_n_i;
  assign mem.mem_resp_v_o    = (state_q == S_RESP);
  assign mem.mem_resp_o      = resp_q;

  yumi_only_with_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem.mem_resp_yumi_i |-> mem.mem_resp_v_o);
endmodule

// File: tb/tb_bsg_chip_mem_responder.sv
// tb/tb_bsg_chip_mem_responder.sv - self-checking bench for bsg_chip_mem_responder
// dut4 runs with latency 4 and 1024 blocks; dut0 runs with latency 0, 16 blocks and a model.
module tb_bsg_chip_mem_responder;
  localparam int PW = 40;
  localparam int BW = 512;
  localparam int MW = 4 + PW + 3 + BW;

  typedef struct {
    logic [3:0]    t;
    logic [PW-1:0] a;
    logic [2:0]    s;
    logic [BW-1:0] d;
    logic [BW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bsg_chip_mem_responder_if #(.msg_width_p(MW)) if4 ();
  bsg_chip_mem_responder_if #(.msg_width_p(MW)) if0 ();

  bsg_chip_mem_responder #(.paddr_width_p(PW), .block_width_p(BW), .els_p(1024), .latency_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .mem(if4));
  bsg_chip_mem_responder #(.paddr_width_p(PW), .block_width_p(BW), .els_p(16), .latency_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .mem(if0));

  assign if0.mem_resp_yumi_i = if0.mem_resp_v_o;

  logic [BW-1:0] mdl0 [16];

  function automatic logic [MW-1:0] make_msg(input logic [3:0] t, input logic [PW-1:0] a,
                                             input logic [2:0] s, input logic [BW-1:0] d);
    return {d, s, a, t};
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference behaviour of the 16-block latency-0 responder, expressed on bytes.
  task automatic model_step(input logic [3:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                            input logic [BW-1:0] d, output logic [BW-1:0] res);
    int idx, n, off, base;
    logic [BW-1:0] cur;
    idx  = int'((a / 64) % 16);
    cur  = mdl0[idx];
    n    = 1 << ((s > 3'd6) ? 6 : int'(s));
    off  = int'(a % 64);
    base = off - (off % n);
    res  = '0;
    case (t)
      4'd1: mdl0[idx] = d;
      4'd3: for (int b = 0; b < n; b++) mdl0[idx][8*(base + b) +: 8] = d[8*b +: 8];
      4'd2: for (int j = 0; j < 64; j++) res[8*j +: 8] = cur[8*(base + (j % n)) +: 8];
      default: res = cur;
    endcase
  endtask

  // Both transaction tasks start and end at posedge+1.
  task automatic txn4(input logic [3:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                      input logic [BW-1:0] d, output logic [MW-1:0] resp, output int lat);
    int k;
    if4.mem_cmd_i   = make_msg(t, a, s, d);
    if4.mem_cmd_v_i = 1'b1;
    k = 0;
    @(negedge clk);
    while (!if4.mem_cmd_ready_o && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    if4.mem_cmd_v_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!if4.mem_resp_v_o && lat < 50) begin @(negedge clk); lat++; end
    resp = if4.mem_resp_o;
    if4.mem_resp_yumi_i = if4.mem_resp_v_o;
    @(posedge clk); #1;
    if4.mem_resp_yumi_i = 1'b0;
  endtask

  task automatic txn0(input logic [3:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                      input logic [BW-1:0] d, output logic [MW-1:0] resp, output int lat);
    if0.mem_cmd_i   = make_msg(t, a, s, d);
    if0.mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    if0.mem_cmd_v_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!if0.mem_resp_v_o && lat < 50) begin @(negedge clk); lat++; end
    resp = if0.mem_resp_o;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t          vecs[12];
    logic [MW-1:0] resp, held;
    logic [BW-1:0] exp_d, pat, r1;
    int            lat, errs, errs2;

    pat = {8{64'h0F1E_2D3C_4B5A_6978}};
    r1  = {16{32'h1357_9BDF}};
    vecs[0]  = '{4'd1, 40'h80_0000_0040, 3'd6, {64{8'hA5}}, '0};
    vecs[1]  = '{4'd0, 40'h80_0000_0040, 3'd6, {16{32'h5555_AAAA}}, {64{8'hA5}}};
    vecs[2]  = '{4'd1, 40'h80, 3'd6, '0, '0};
    vecs[3]  = '{4'd3, 40'h88, 3'd2, {{15{32'hCAFE_F00D}}, 32'hDEAD_BEEF}, '0};
    vecs[4]  = '{4'd2, 40'h88, 3'd2, '0, {16{32'hDEAD_BEEF}}};
    vecs[5]  = '{4'd0, 40'h80, 3'd6, '0, {416'b0, 32'hDEAD_BEEF, 64'b0}};
    vecs[6]  = '{4'd1, 40'h140, 3'd6, pat, '0};
    vecs[7]  = '{4'd0, 40'h1_0140, 3'd6, '0, pat};
    vecs[8]  = '{4'd7, 40'h1_0140, 3'd6, '0, pat};
    vecs[9]  = '{4'd2, 40'h153, 3'd7, '0, pat};
    vecs[10] = '{4'd3, 40'h85, 3'd0, {{63{8'h99}}, 8'h77}, '0};
    vecs[11] = '{4'd2, 40'h84, 3'd1, '0, {32{16'h7700}}};

    rst_n = 1'b0;
    if4.mem_cmd_i = '0; if4.mem_cmd_v_i = 1'b0; if4.mem_resp_yumi_i = 1'b0;
    if0.mem_cmd_i = '0; if0.mem_cmd_v_i = 1'b0;

    #12;
    check("reset_ready_low", MW'(if4.mem_cmd_ready_o), MW'(0));
    check("reset_resp_v", MW'(if4.mem_resp_v_o), MW'(0));
    check("reset_resp", if4.mem_resp_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", MW'(if4.mem_cmd_ready_o), MW'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      txn4(vecs[i].t, vecs[i].a, vecs[i].s, vecs[i].d, resp, lat);
      check($sformatf("vec%0d_resp", i), resp, make_msg(vecs[i].t, vecs[i].a, vecs[i].s, vecs[i].exp_data));
      check($sformatf("vec%0d_latency", i), MW'(lat), MW'(5));
    end

    // Backpressure: second command held valid while the first response is stalled.
    if4.mem_cmd_i   = make_msg(4'd1, 40'h200, 3'd6, r1);
    if4.mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    if4.mem_cmd_i = make_msg(4'd0, 40'h200, 3'd6, '0);
    lat = 0;
    @(negedge clk);
    while (!if4.mem_resp_v_o && lat < 50) begin @(negedge clk); lat++; end
    held = if4.mem_resp_o;
    check("bp_first_resp", held, make_msg(4'd1, 40'h200, 3'd6, '0));
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if4.mem_resp_o !== held || if4.mem_cmd_ready_o !== 1'b0 || if4.mem_resp_v_o !== 1'b1) errs++;
    end
    check("bp_hold_cycles_bad", MW'(errs), MW'(0));
    if4.mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    if4.mem_resp_yumi_i = 1'b0;
    @(negedge clk);
    check("bp_ready_after_yumi", MW'(if4.mem_cmd_ready_o), MW'(1));
    @(posedge clk); #1;
    if4.mem_cmd_v_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!if4.mem_resp_v_o && lat < 50) begin @(negedge clk); lat++; end
    check("bp_second_latency", MW'(lat), MW'(5));
    check("bp_second_resp", if4.mem_resp_o, make_msg(4'd0, 40'h200, 3'd6, r1));
    if4.mem_resp_yumi_i = if4.mem_resp_v_o;
    @(posedge clk); #1;
    if4.mem_resp_yumi_i = 1'b0;

    // Latency 0 with yumi following valid: strict alternation of accept and response.
    exp_d = rand_blk();
    if0.mem_cmd_i   = make_msg(4'd1, 40'h0, 3'd6, exp_d);
    if0.mem_cmd_v_i = 1'b1;
    errs = 0;
    errs2 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if0.mem_cmd_ready_o !== (c % 2 == 0)) errs++;
      if (if0.mem_resp_v_o !== (c % 2 == 1)) errs2++;
    end
    @(posedge clk); #1;
    if0.mem_cmd_v_i = 1'b0;
    check("lat0_ready_pattern_bad", MW'(errs), MW'(0));
    check("lat0_resp_v_pattern_bad", MW'(errs2), MW'(0));
    model_step(4'd1, 40'h0, 3'd6, exp_d, exp_d);

    for (int b = 1; b < 16; b++) begin
      logic [BW-1:0] d;
      d = rand_blk();
      model_step(4'd1, PW'(b * 64), 3'd6, d, exp_d);
      txn0(4'd1, PW'(b * 64), 3'd6, d, resp, lat);
      check($sformatf("fill%0d", b), resp, make_msg(4'd1, PW'(b * 64), 3'd6, exp_d));
    end

    for (int n = 0; n < 200; n++) begin
      logic [3:0]    t;
      logic [PW-1:0] a;
      logic [2:0]    s;
      logic [BW-1:0] d;
      t = 4'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 7));
      a = {8'($urandom), 32'($urandom)};
      d = rand_blk();
      model_step(t, a, s, d, exp_d);
      txn0(t, a, s, d, resp, lat);
      check($sformatf("rand%0d_resp", n), resp, make_msg(t, a, s, exp_d));
      check($sformatf("rand%0d_latency", n), MW'(lat), MW'(1));
    end

    // Asynchronous reset while dut4 is waiting: transaction dropped, array kept.
    if4.mem_cmd_i   = make_msg(4'd0, 40'h1_0140, 3'd6, '0);
    if4.mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    if4.mem_cmd_v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_resp_v", MW'(if4.mem_resp_v_o), MW'(0));
    check("rst_wait_ready", MW'(if4.mem_cmd_ready_o), MW'(0));
    check("rst_wait_resp", if4.mem_resp_o, '0);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    errs = 0;
    errs2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if4.mem_resp_v_o !== 1'b0) errs++;
      if (if4.mem_cmd_ready_o !== 1'b1) errs2++;
    end
    check("rst_stale_resp_cycles", MW'(errs), MW'(0));
    check("rst_not_ready_cycles", MW'(errs2), MW'(0));
    @(posedge clk); #1;
    txn4(4'd0, 40'h140, 3'd6, '0, resp, lat);
    check("rst_persist_resp", resp, make_msg(4'd0, 40'h140, 3'd6, pat));
    check("rst_persist_latency", MW'(lat), MW'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
